// File: rtl/tank_pkg.sv
// Shared definitions for the tank game: directions, tile codes, map geometry
// and the bullet engine state encoding.
package tank_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLIGHT = 3'd1,
    S_MOVE   = 3'd2,
    S_LOOKUP = 3'd3,
    S_CHECK  = 3'd4
  } bullet_state_t;

  localparam logic [2:0] TILE_EMPTY = 3'd0;
  localparam logic [2:0] TILE_WALL  = 3'd1;
  localparam logic [2:0] TILE_BRICK = 3'd2;
  localparam logic [2:0] TILE_BASE1 = 3'd3;
  localparam logic [2:0] TILE_BASE2 = 3'd4;

  localparam int MAP_W      = 20;
  localparam int MAP_H      = 15;
  localparam int TILE_SHIFT = 5;
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;

endpackage

// File: rtl/tile_addr.sv
// Pixel (x,y) to 9-bit tile index on the 20-wide map; shared with tank movement.
// y*20 is formed as (y<<4)+(y<<2) to avoid a multiplier.
module tile_addr
  import tank_pkg::*;
(
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [8:0] idx
);

  logic [4:0] tx;
  logic [4:0] ty;

  assign tx  = x[9:TILE_SHIFT];
  assign ty  = y[9:TILE_SHIFT];
  assign idx = {ty, 4'b0000} + {2'b00, ty, 2'b00} + {4'b0000, tx};

endmodule

// File: rtl/bullet_unit.sv
// Per-player bullet engine: spawns on a fire-key edge, steps once per frame,
// looks up the tile under the bullet and emits destroy/base/tank pulses.
// Optional enemy-tank collision is built when BULLET_TANK_HIT_EN is defined.
module bullet_unit
  import tank_pkg::*;
#(
  parameter int         PLAYER      = 1,
  parameter logic [7:0] FIRE_KEY    = 8'h2C,
  parameter int         BULLET_STEP = 4,
  parameter int         SPAWN_OFS   = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [1:0] TankDir,
  input  logic [9:0] EnemyX,
  input  logic [9:0] EnemyY,
  output logic [8:0] tile_idx,
  input  logic [2:0] tile_val,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic       BulletActive,
  output logic       destroy_valid,
  output logic [8:0] destroy_idx,
  output logic       base_hit,
  output logic       tank_hit,
  output logic [2:0] dbg_state
);

  localparam logic signed [10:0] STEP  = 11'(BULLET_STEP);
  localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - 1);
  localparam logic [9:0]         OFS   = 10'(SPAWN_OFS);
  localparam logic [2:0]         ENEMY_BASE = (PLAYER == 1) ? TILE_BASE2 : TILE_BASE1;

  bullet_state_t state, state_next;
  logic       fs1, fs2, fs3;
  logic       tick, fire_now, fire_prev, fire_req;
  dir_t       dir_q, dir_d;
  logic [9:0] x_d, y_d, spawn_x, spawn_y;
  logic [8:0] didx_d;
  logic       active_d, destroy_d, base_d, tank_d, oob, hit_tank;
  logic signed [10:0] mx, my;

  // frame_clk is asynchronous; fs3 holds the previous synchronised level.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fs1 <= 1'b0; fs2 <= 1'b0; fs3 <= 1'b0;
      fire_prev <= 1'b0;
    end else begin
      fs1 <= frame_clk; fs2 <= fs1; fs3 <= fs2;
      if (tick) fire_prev <= fire_now;
    end
  end

  assign tick     = fs2 & ~fs3;
  assign fire_now = (keycode == FIRE_KEY);
  assign fire_req = tick & fire_now & ~fire_prev;

  tile_addr u_addr (.x(BulletX), .y(BulletY), .idx(tile_idx));

`ifdef BULLET_TANK_HIT_EN
  logic signed [10:0] dx, dy;
  assign dx = $signed({1'b0, BulletX}) - $signed({1'b0, EnemyX});
  assign dy = $signed({1'b0, BulletY}) - $signed({1'b0, EnemyY});
  assign hit_tank = (dx > -11'sd16) && (dx < 11'sd16) && (dy > -11'sd16) && (dy < 11'sd16);
`else
  logic unused_enemy;
  assign unused_enemy = ^{EnemyX, EnemyY};
  assign hit_tank = 1'b0;
`endif

  // Candidate next position along the latched direction, signed to catch underflow.
  always_comb begin
    mx = $signed({1'b0, BulletX});
    my = $signed({1'b0, BulletY});
    unique case (dir_q)
      UP:    my = my - STEP;
      RIGHT: mx = mx + STEP;
      DOWN:  my = my + STEP;
      LEFT:  mx = mx - STEP;
      default: ;
    endcase
  end

  assign oob = (mx < 11'sd0) || (mx > X_MAX) || (my < 11'sd0) || (my > Y_MAX);

  always_comb begin
    spawn_x = TankX;
    spawn_y = TankY;
    unique case (dir_t'(TankDir))
      UP:    spawn_y = TankY - OFS;
      RIGHT: spawn_x = TankX + OFS;
      DOWN:  spawn_y = TankY + OFS;
      LEFT:  spawn_x = TankX - OFS;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (fire_req) state_next = S_LOOKUP;
      S_FLIGHT: if (tick) state_next = S_MOVE;
      S_MOVE:   state_next = oob ? S_IDLE : S_LOOKUP;
      S_LOOKUP: state_next = S_CHECK;
      S_CHECK:  state_next = (!hit_tank && tile_val == TILE_EMPTY) ? S_FLIGHT : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    x_d = BulletX; y_d = BulletY; dir_d = dir_q;
    active_d = BulletActive; didx_d = destroy_idx;
    destroy_d = 1'b0; base_d = 1'b0; tank_d = 1'b0;
    unique case (state)
      S_IDLE: if (fire_req) begin
        x_d = spawn_x; y_d = spawn_y; dir_d = dir_t'(TankDir); active_d = 1'b1;
      end
      S_MOVE: begin
        if (oob) active_d = 1'b0;
        else begin x_d = mx[9:0]; y_d = my[9:0]; end
      end
      S_CHECK: begin
        if (hit_tank) begin
          tank_d = 1'b1; active_d = 1'b0;
        end else if (tile_val == TILE_EMPTY) begin
          active_d = 1'b1;
        end else if (tile_val == TILE_BRICK) begin
          destroy_d = 1'b1; didx_d = tile_idx; active_d = 1'b0;
        end else if (tile_val == ENEMY_BASE) begin
          base_d = 1'b1; active_d = 1'b0;
        end else begin
          active_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      BulletX <= '0; BulletY <= '0; BulletActive <= 1'b0; dir_q <= UP;
      destroy_valid <= 1'b0; destroy_idx <= '0; base_hit <= 1'b0; tank_hit <= 1'b0;
    end else begin
      BulletX <= x_d; BulletY <= y_d; BulletActive <= active_d; dir_q <= dir_d;
      destroy_valid <= destroy_d; destroy_idx <= didx_d;
      base_hit <= base_d; tank_hit <= tank_d;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_bullet_unit.sv
// Directed bench for bullet_unit: event pulses are matched against an expected
// queue by a negedge monitor; positions and state are checked at fixed latencies.
module tb_bullet_unit;
  import tank_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] TankX = '0, TankY = '0, EnemyX = '0, EnemyY = '0;
  logic [1:0] TankDir = 2'd0;
  logic [2:0] tile_val = 3'd0;
  logic [8:0] tile_idx, destroy_idx;
  logic [9:0] BulletX, BulletY;
  logic       BulletActive, destroy_valid, base_hit, tank_hit;
  logic [2:0] dbg_state;

  logic [2:0]  map_mem [300];
  logic [11:0] exp_q[$];
  logic [11:0] got, e;
  int vectors = 0;
  int miscompares = 0;

  bullet_unit dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .TankX(TankX), .TankY(TankY), .TankDir(TankDir),
    .EnemyX(EnemyX), .EnemyY(EnemyY),
    .tile_idx(tile_idx), .tile_val(tile_val),
    .BulletX(BulletX), .BulletY(BulletY), .BulletActive(BulletActive),
    .destroy_valid(destroy_valid), .destroy_idx(destroy_idx),
    .base_hit(base_hit), .tank_hit(tank_hit), .dbg_state(dbg_state)
  );

  // Clock and map memory model (one-cycle read latency).
  always #10 Clk = ~Clk;
  always @(posedge Clk) tile_val <= (tile_idx < 9'd300) ? map_mem[tile_idx] : TILE_WALL;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Event monitor: {tank, base, destroy, idx-if-destroy}.
  always @(negedge Clk) begin
    if (destroy_valid || base_hit || tank_hit) begin
      got = {tank_hit, base_hit, destroy_valid, destroy_valid ? destroy_idx : 9'd0};
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: got %h expected none", got);
      end else begin
        e = exp_q.pop_front();
        check("event", int'(got), int'(e));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n = 0;
    while (dbg_state !== s && n < 12) begin
      step(1);
      n++;
    end
    check(name, int'(dbg_state), int'(s));
  endtask

  task automatic frame_end();
    frame_clk = 1'b0;
    step(8);
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    step(8);
    frame_end();
  endtask

  task automatic clear_map();
    for (int i = 0; i < 300; i++) map_mem[i] = TILE_EMPTY;
  endtask

  // Release the key for a frame, then press it; returns in LOOKUP after spawn.
  task automatic fire(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d);
    keycode = 8'h00;
    frame();
    TankX = x; TankY = y; TankDir = d;
    keycode = 8'h2C;
    frame_clk = 1'b1;
    wait_state(S_LOOKUP, "spawn_state");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, BulletX, 0);
    check({tag, "_y"}, BulletY, 0);
    check({tag, "_active"}, BulletActive, 0);
    check({tag, "_idx"}, tile_idx, 0);
    check({tag, "_pulses"}, {destroy_valid, base_hit, tank_hit}, 0);
    check({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  initial begin
    clear_map();
    step(3);
    check_reset_outputs("in_reset");
    Reset = 1'b0;
    step(1);
    check_reset_outputs("after_reset");

    // Spawn to the right of (320,240) and first step.
    fire(10'd320, 10'd240, 2'd1);
    check("spawn_x", BulletX, 336);
    check("spawn_y", BulletY, 240);
    check("spawn_idx", tile_idx, 150);
    check("spawn_active", BulletActive, 1);
    frame_end();
    frame_clk = 1'b1;
    wait_state(S_MOVE, "move_state");
    step(1);
    check("step1_x", BulletX, 340);
    check("step1_idx", tile_idx, 150);
    check("step1_state", dbg_state, S_LOOKUP);
    frame_end();

    // Key still held: bullet hits a wall at 352, no respawn afterwards.
    map_mem[151] = TILE_WALL;
    repeat (3) frame();
    check("wall_active", BulletActive, 0);
    repeat (6) frame();
    check("held_active", BulletActive, 0);
    check("held_state", dbg_state, S_IDLE);
    check("held_x", BulletX, 352);

    // Brick at 149, fired left; tank rotates mid-flight.
    clear_map();
    map_mem[149] = TILE_BRICK;
    fire(10'd352, 10'd240, 2'd3);
    check("left_spawn_x", BulletX, 336);
    TankDir = 2'd0;
    frame_end();
    repeat (4) frame();
    check("left_x", BulletX, 320);
    check("left_active", BulletActive, 1);
    exp_q.push_back({3'b001, 9'd149});
    frame_clk = 1'b1;
    wait_state(S_MOVE, "brick_move");
    step(1);
    check("brick_x", BulletX, 316);
    check("brick_idx", tile_idx, 149);
    step(1);
    check("brick_t3_state", dbg_state, S_CHECK);
    check("brick_t3_active", BulletActive, 1);
    step(1);
    check("brick_t4_active", BulletActive, 0);
    check("brick_t4_didx", destroy_idx, 149);
    check("brick_t4_state", dbg_state, S_IDLE);
    frame_end();

    // Enemy base (tile 4) hit, then own base (tile 3) without a pulse.
    clear_map();
    map_mem[130] = TILE_BASE2;
    fire(10'd320, 10'd240, 2'd0);
    check("up_spawn_y", BulletY, 224);
    check("up_spawn_idx", tile_idx, 150);
    frame_end();
    exp_q.push_back({3'b010, 9'd0});
    frame();
    check("base_y", BulletY, 220);
    check("base_active", BulletActive, 0);
    map_mem[130] = TILE_BASE1;
    fire(10'd320, 10'd240, 2'd0);
    frame_end();
    frame();
    check("own_base_active", BulletActive, 0);
    check("own_base_state", dbg_state, S_IDLE);

    // Screen edges: Y reaches 0 then leaves; X 636 -> 640 leaves.
    clear_map();
    fire(10'd320, 10'd24, 2'd0);
    check("top_spawn_y", BulletY, 8);
    frame_end();
    frame();
    frame();
    check("top_y0", BulletY, 0);
    check("top_y0_active", BulletActive, 1);
    frame_clk = 1'b1;
    wait_state(S_MOVE, "top_move");
    step(1);
    check("top_oob_active", BulletActive, 0);
    check("top_oob_state", dbg_state, S_IDLE);
    frame_end();
    fire(10'd620, 10'd100, 2'd1);
    check("right_spawn_x", BulletX, 636);
    frame_end();
    frame();
    check("right_oob_active", BulletActive, 0);
    check("right_oob_x", BulletX, 636);

    // Reset while in LOOKUP over a brick: no destroy pulse must follow.
    clear_map();
    map_mem[150] = TILE_BRICK;
    fire(10'd320, 10'd240, 2'd1);
    Reset = 1'b1;
    frame_clk = 1'b0;
    step(1);
    check_reset_outputs("mid_reset");
    Reset = 1'b0;
    keycode = 8'h00;
    step(8);

    // Enemy tank overlap at spawn (400,100) vs (410,95) over a brick.
    clear_map();
    map_mem[72] = TILE_BRICK;
    EnemyX = 10'd410;
    EnemyY = 10'd95;
`ifdef BULLET_TANK_HIT_EN
    exp_q.push_back({3'b100, 9'd0});
`else
    exp_q.push_back({3'b001, 9'd72});
`endif
    fire(10'd400, 10'd116, 2'd0);
    check("tank_spawn_idx", tile_idx, 72);
    frame_end();
    check("tank_active", BulletActive, 0);

    step(10);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
